// File: rtl/motor_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : motor_step_decoder
// Brief    : Step/dir pin receiver. Synchronizes the pins, detects step
//            rising edges, tracks a signed position and checks pin timing
//            (dir setup, step high width, step low gap) against run-time
//            minimums, raising sticky violation flags.
// Revision : 1.0 - initial release
// ============================================================================
module motor_step_decoder (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               step_in_i,
  input  logic               dir_in_i,
  input  logic               invert_dir_i,
  input  logic [31:0]        min_setup_i,
  input  logic [31:0]        min_high_i,
  input  logic [31:0]        min_low_i,
  input  logic               clear_err_i,
  output logic               step_stb_o,
  output logic               step_dir_o,
  input  logic               set_x_i,
  input  logic signed [31:0] x_val_i,
  output logic signed [31:0] x_o,
  input  logic               hold_i,
  output logic signed [31:0] x_hold_o,
  output logic               setup_err_o,
  output logic               width_err_o,
  output logic               gap_err_o
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  // Only the low 16 bits of each timing limit take part in the checks.
  logic [15:0] w_min_setup;
  logic [15:0] w_min_high;
  logic [15:0] w_min_low;

  assign w_min_setup = min_setup_i[15:0];
  assign w_min_high  = min_high_i[15:0];
  assign w_min_low   = min_low_i[15:0];

  // --------------------------------------------------------------------------
  // Registers (_q) and their next-state values (_d)
  // --------------------------------------------------------------------------
  logic               step_s1_q,  step_s2_q,  step_dly_q;
  logic               dir_s1_q,   dir_s2_q,   dir_dly_q;
  logic [15:0]        high_cnt_q, high_cnt_d;
  logic [15:0]        low_cnt_q,  low_cnt_d;
  logic [15:0]        dir_age_q,  dir_age_d;
  logic               step_stb_q, step_stb_d;
  logic               step_dir_q, step_dir_d;
  logic signed [31:0] x_q,        x_d;
  logic signed [31:0] x_hold_q,   x_hold_d;
  logic               setup_err_q, setup_err_d;
  logic               width_err_q, width_err_d;
  logic               gap_err_q,   gap_err_d;

  // Edge / change detection on the synchronized pins
  logic        w_rise;
  logic        w_fall;
  logic        w_dir_chg;
  logic [15:0] w_dir_age_eff;
  logic        w_dir_new;
  logic        w_setup_viol;
  logic        w_width_viol;
  logic        w_gap_viol;

  assign w_rise    =  step_s2_q & ~step_dly_q;
  assign w_fall    = ~step_s2_q &  step_dly_q;
  assign w_dir_chg =  dir_s2_q ^ dir_dly_q;

  // A dir change coinciding with the step rise counts as zero setup time.
  assign w_dir_age_eff = w_dir_chg ? 16'd0 : dir_age_q;
  assign w_dir_new     = dir_s2_q ^ invert_dir_i;

  // A limit of zero can never be undercut, so zero disables the check.
  // A saturated counter (FFFF) is never below any 16-bit limit.
  assign w_setup_viol = w_rise & (w_dir_age_eff < w_min_setup);
  assign w_gap_viol   = w_rise & (low_cnt_q     < w_min_low);
  assign w_width_viol = w_fall & (high_cnt_q    < w_min_high);

  // Two-flop synchronizers on both pins plus one delay flop each for
  // edge (step) and change (dir) detection.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      step_dly_q <= 1'b0;
      dir_s1_q   <= 1'b0;
      dir_s2_q   <= 1'b0;
      dir_dly_q  <= 1'b0;
    end else begin
      step_s1_q  <= step_in_i;
      step_s2_q  <= step_s1_q;
      step_dly_q <= step_s2_q;
      dir_s1_q   <= dir_in_i;
      dir_s2_q   <= dir_s1_q;
      dir_dly_q  <= dir_s2_q;
    end
  end

  // Saturating timing counters: high width, low gap and dir stable age.
  always_comb begin
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    dir_age_d  = dir_age_q;

    if (w_rise) begin
      high_cnt_d = 16'd0;
    end else if (step_s2_q && (high_cnt_q != C_CNT_MAX)) begin
      high_cnt_d = high_cnt_q + 16'd1;
    end

    if (w_fall) begin
      low_cnt_d = 16'd0;
    end else if (!step_s2_q && (low_cnt_q != C_CNT_MAX)) begin
      low_cnt_d = low_cnt_q + 16'd1;
    end

    if (w_dir_chg) begin
      dir_age_d = 16'd0;
    end else if (dir_age_q != C_CNT_MAX) begin
      dir_age_d = dir_age_q + 16'd1;
    end
  end

  // Step strobe, direction and position; set_x overrides the step update.
  always_comb begin
    step_stb_d = w_rise;
    step_dir_d = step_dir_q;
    x_d        = x_q;
    x_hold_d   = x_hold_q;

    if (w_rise) begin
      step_dir_d = w_dir_new;
      x_d        = w_dir_new ? (x_q - 32'sd1) : (x_q + 32'sd1);
    end

    if (set_x_i) begin
      x_d = x_val_i;
    end

    // Hold captures the position as it stands before this cycle's update.
    if (hold_i) begin
      x_hold_d = x_q;
    end
  end

  // Sticky error flags; a new violation beats a simultaneous clear.
  always_comb begin
    setup_err_d = (setup_err_q & ~clear_err_i) | w_setup_viol;
    width_err_d = (width_err_q & ~clear_err_i) | w_width_viol;
    gap_err_d   = (gap_err_q   & ~clear_err_i) | w_gap_viol;
  end

  // State registers. Counters preset to saturation so the first step after
  // reset is never flagged.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      high_cnt_q  <= C_CNT_MAX;
      low_cnt_q   <= C_CNT_MAX;
      dir_age_q   <= C_CNT_MAX;
      step_stb_q  <= 1'b0;
      step_dir_q  <= 1'b0;
      x_q         <= 32'sd0;
      x_hold_q    <= 32'sd0;
      setup_err_q <= 1'b0;
      width_err_q <= 1'b0;
      gap_err_q   <= 1'b0;
    end else begin
      high_cnt_q  <= high_cnt_d;
      low_cnt_q   <= low_cnt_d;
      dir_age_q   <= dir_age_d;
      step_stb_q  <= step_stb_d;
      step_dir_q  <= step_dir_d;
      x_q         <= x_d;
      x_hold_q    <= x_hold_d;
      setup_err_q <= setup_err_d;
      width_err_q <= width_err_d;
      gap_err_q   <= gap_err_d;
    end
  end

  assign step_stb_o  = step_stb_q;
  assign step_dir_o  = step_dir_q;
  assign x_o         = x_q;
  assign x_hold_o    = x_hold_q;
  assign setup_err_o = setup_err_q;
  assign width_err_o = width_err_q;
  assign gap_err_o   = gap_err_q;

endmodule
`default_nettype wire

// File: tb/tb_motor_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_step_decoder
// Brief    : Directed self-checking bench for motor_step_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_step_decoder;

  logic               clk;
  logic               reset;
  logic               step_in;
  logic               dir_in;
  logic               invert_dir;
  logic [31:0]        min_setup;
  logic [31:0]        min_high;
  logic [31:0]        min_low;
  logic               clear_err;
  logic               step_stb;
  logic               step_dir;
  logic               set_x;
  logic signed [31:0] x_val;
  logic signed [31:0] x;
  logic               hold;
  logic signed [31:0] x_hold;
  logic               setup_err;
  logic               width_err;
  logic               gap_err;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;
  int base;

  motor_step_decoder dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .step_in_i    (step_in),
    .dir_in_i     (dir_in),
    .invert_dir_i (invert_dir),
    .min_setup_i  (min_setup),
    .min_high_i   (min_high),
    .min_low_i    (min_low),
    .clear_err_i  (clear_err),
    .step_stb_o   (step_stb),
    .step_dir_o   (step_dir),
    .set_x_i      (set_x),
    .x_val_i      (x_val),
    .x_o          (x),
    .hold_i       (hold),
    .x_hold_o     (x_hold),
    .setup_err_o  (setup_err),
    .width_err_o  (width_err),
    .gap_err_o    (gap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe pulses are counted on the falling edge, away from the active edge.
  always @(negedge clk) if (step_stb) stb_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input int hi, input int lo);
    step_in = 1'b1;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
  endtask

  initial begin
    reset = 1'b1; step_in = 1'b0; dir_in = 1'b0; invert_dir = 1'b0;
    min_setup = 32'd0; min_high = 32'd0; min_low = 32'd0;
    clear_err = 1'b0; set_x = 1'b0; x_val = 32'sd0; hold = 1'b0;
    tick(3);
    check("rst_x", x, 32'd0);
    check("rst_stb", {31'd0, step_stb}, 32'd0);
    check("rst_dir", {31'd0, step_dir}, 32'd0);
    check("rst_hold", x_hold, 32'd0);
    check("rst_errs", {29'd0, setup_err, width_err, gap_err}, 32'd0);
    reset = 1'b0;

    // Nominal loopback: 5 up, 3 down
    min_setup = 32'd2; min_high = 32'd3; min_low = 32'd3;
    tick(10);
    base = stb_cnt;
    for (int i = 0; i < 5; i++) do_step(5, 5);
    dir_in = 1'b1;
    tick(10);
    for (int i = 0; i < 3; i++) do_step(5, 5);
    tick(4);
    check("nom_stb_cnt", stb_cnt - base, 32'd8);
    check("nom_x", x, 32'd2);
    check("nom_dir", {31'd0, step_dir}, 32'd1);
    check("nom_errs", {29'd0, setup_err, width_err, gap_err}, 32'd0);

    // Latency and polarity: reset to start from x=0
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    invert_dir = 1'b1; dir_in = 1'b1;
    tick(10);
    step_in = 1'b1;             // sampled at edge N
    check("lat_n", {31'd0, step_stb}, 32'd0);
    tick(1);                    // after N
    check("lat_n0", {31'd0, step_stb}, 32'd0);
    tick(1);                    // after N+1
    check("lat_n1", {31'd0, step_stb}, 32'd0);
    tick(1);                    // after N+2
    check("lat_n2", {31'd0, step_stb}, 32'd1);
    check("lat_dir", {31'd0, step_dir}, 32'd0);
    check("lat_x", x, 32'd1);
    tick(1);
    check("lat_n3", {31'd0, step_stb}, 32'd0);
    tick(2);
    step_in = 1'b0;
    tick(6);

    // Setup violation: dir toggled 2 cycles before step
    invert_dir = 1'b0; min_setup = 32'd4;
    dir_in = 1'b0;
    tick(2);
    do_step(5, 6);
    check("setup_err", {31'd0, setup_err}, 32'd1);
    check("setup_x", x, 32'd2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("setup_clr", {31'd0, setup_err}, 32'd0);
    tick(5);
    // Repeat with clear_err on the violation cycle
    dir_in = 1'b1;
    tick(2);
    step_in = 1'b1;
    tick(2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("setup_clr_race", {31'd0, setup_err}, 32'd1);
    tick(2);
    step_in = 1'b0;
    tick(6);
    check("setup_x2", x, 32'd1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(10);

    // Width / gap violations, dir=1 so both steps decrement
    min_high = 32'd4; min_low = 32'd4;
    base = stb_cnt;
    do_step(2, 2);
    do_step(5, 6);
    check("width_err", {31'd0, width_err}, 32'd1);
    check("gap_err", {31'd0, gap_err}, 32'd1);
    check("wg_setup", {31'd0, setup_err}, 32'd0);
    check("wg_x", x, 32'hFFFF_FFFF);
    check("wg_stb_cnt", stb_cnt - base, 32'd2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("wg_clr", {29'd0, setup_err, width_err, gap_err}, 32'd0);

    // set_x / hold collision with a step update
    set_x = 1'b1; x_val = 32'sd10;
    tick(1);
    set_x = 1'b0;
    dir_in = 1'b0;
    tick(10);
    step_in = 1'b1;
    tick(2);
    set_x = 1'b1; x_val = -32'sd5; hold = 1'b1;
    tick(1);
    set_x = 1'b0; hold = 1'b0;
    check("col_x", x, 32'hFFFF_FFFB);
    check("col_hold", x_hold, 32'd10);
    check("col_stb", {31'd0, step_stb}, 32'd1);
    check("col_dir", {31'd0, step_dir}, 32'd0);
    tick(4);
    step_in = 1'b0;
    tick(6);

    // Reset mid-operation while step_in is high
    do_step(2, 6);              // short pulse -> width_err
    check("pre_rst_width", {31'd0, width_err}, 32'd1);
    set_x = 1'b1; x_val = 32'sd7;
    tick(1);
    set_x = 1'b0;
    check("pre_rst_x", x, 32'd7);
    step_in = 1'b1; reset = 1'b1;
    tick(3);
    check("mid_rst_x", x, 32'd0);
    check("mid_rst_hold", x_hold, 32'd0);
    check("mid_rst_outs", {28'd0, step_stb, setup_err, width_err, gap_err}, 32'd0);
    check("mid_rst_dir", {31'd0, step_dir}, 32'd0);
    base = stb_cnt;
    reset = 1'b0;
    tick(8);
    check("post_rst_stb", stb_cnt - base, 32'd1);
    check("post_rst_x", x, 32'd1);
    check("post_rst_errs", {29'd0, setup_err, width_err, gap_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
